// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation controller.
package puf_pkg;

  localparam int C_LENGTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RACE,
    SAMPLE,
    DONE
  } state_e;

  // Bits needed to encode value-1; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous arbiter decision into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the
  // pre-edge values; a blocking chain would collapse the synchroniser to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Drives N_EVAL settle/race cycles per challenge into the delay line and
// majority-votes the synchronised arbiter decisions into one response bit.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int C_LENGTH   = C_LENGTH_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int RACE_CYC   = 8,
  parameter int N_EVAL     = 15,
  parameter int CNT_W      = clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_LENGTH-1:0] chal_in,
  input  logic                chal_valid,
  output logic                chal_ready,
  output logic [C_LENGTH-1:0] challenge,
  output logic                ipulse,
  input  logic                arb_resp,
  output logic                resp,
  output logic [CNT_W-1:0]    ones_count,
  output logic                unstable,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                busy
);

  // Wide enough for either reload value.
  localparam int TIMER_W = clog2(SETTLE_CYC + RACE_CYC);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] RACE_LOAD   = TIMER_W'(RACE_CYC - 1);
  localparam logic [CNT_W-1:0]   LAST_EVAL   = CNT_W'(N_EVAL - 1);
  localparam logic [CNT_W-1:0]   ALL_ONES    = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0]   HALF        = CNT_W'(N_EVAL / 2);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]      eval_cnt_q, eval_cnt_d;
  logic [CNT_W-1:0]      ones_q, ones_d;
  logic [C_LENGTH-1:0]   chal_q, chal_d;
  logic                  ipulse_q, ipulse_d;
  logic                  arb_sync;

  sync_2ff u_arb_sync (
    .clk (clk),
    .rst (rst),
    .d_i (arb_resp),
    .q_o (arb_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      eval_cnt_q <= '0;
      ones_q     <= '0;
      chal_q     <= '0;
      ipulse_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      eval_cnt_q <= eval_cnt_d;
      ones_q     <= ones_d;
      chal_q     <= chal_d;
      ipulse_q   <= ipulse_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    eval_cnt_d = eval_cnt_q;
    ones_d     = ones_q;
    chal_d     = chal_q;

    unique case (state_q)
      IDLE: begin
        if (chal_valid) begin
          chal_d     = chal_in;
          eval_cnt_d = '0;
          ones_d     = '0;
          timer_d    = SETTLE_LOAD;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          timer_d = RACE_LOAD;
          state_d = RACE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      RACE: begin
        if (timer_q == '0) begin
          state_d = SAMPLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      SAMPLE: begin
        ones_d = ones_q + CNT_W'(arb_sync);
        if (eval_cnt_q == LAST_EVAL) begin
          state_d = DONE;
        end else begin
          eval_cnt_d = eval_cnt_q + 1'b1;
          timer_d    = SETTLE_LOAD;
          state_d    = SETTLE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so the pulse is glitch-free and exactly
    // aligned with the RACE window.
    ipulse_d = (state_d == RACE);
  end

  assign chal_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign challenge  = chal_q;
  assign ipulse     = ipulse_q;
  assign ones_count = ones_q;
  assign resp       = (ones_q > HALF);
  assign unstable   = (ones_q != '0) && (ones_q != ALL_ONES);

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Evaluation controller for the arbiter PUF.
- Accepts a challenge over a valid/ready handshake and drives the challenge bus and race pulse into the delay line for a fixed number of evaluations.
- Samples the synchronised arbiter decision after each race and returns a majority-voted response bit with the ones count and an instability flag.
- Sits directly upstream of the delay line, driving its pulse input and challenge bus, and downstream of the arbiter latch.

Parameters:
- C_LENGTH, 32: challenge width; must equal the delay-line stage count.
- SETTLE_CYC, 4: cycles with ipulse low before each race (drain/re-arm); must be >=1.
- RACE_CYC, 8: cycles ipulse is held high per race; must be >=3 to cover synchroniser latency.
- N_EVAL, 15: evaluations per challenge; odd, >=1.
- CNT_W, clog2(N_EVAL+1): width of the ones counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- chal_in  in  C_LENGTH  challenge to evaluate.
- chal_valid  in  1  chal_in valid.
- chal_ready  out  1  controller can accept a challenge.
- challenge  out  C_LENGTH  registered challenge bus to the delay line.
- ipulse  out  1  registered race pulse to the delay line.
- arb_resp  in  1  arbiter latch output; asynchronous to clk.
- resp  out  1  majority-voted response.
- ones_count  out  CNT_W  number of evaluations that returned 1.
- unstable  out  1  ones_count is neither 0 nor N_EVAL.
- resp_valid  out  1  resp, ones_count and unstable are valid.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  state is not IDLE.

Behaviour:
- Decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except chal_ready, which is 1 once IDLE is entered. ipulse goes to 0 immediately on rst assertion.
- arb_resp passes through a 2-flop synchroniser (arb_sync) before use.
- IDLE: chal_ready=1, ipulse=0.
  - On chal_valid&chal_ready: register chal_in onto challenge, clear eval_cnt and ones, load timer=SETTLE_CYC-1, go to SETTLE.
- SETTLE: ipulse=0; timer decrements each cycle.
  - At timer==0: load timer=RACE_CYC-1, go to RACE.
- RACE: ipulse=1; timer decrements each cycle.
  - At timer==0: go to SAMPLE.
- SAMPLE (one cycle): ipulse=0; ones += arb_sync.
  - If eval_cnt==N_EVAL-1: go to DONE.
  - Else: eval_cnt++, load timer=SETTLE_CYC-1, go to SETTLE.
- DONE: resp_valid=1.
  - resp = (ones > N_EVAL/2).
  - ones_count = ones.
  - unstable = (ones!=0 && ones!=N_EVAL).
  - All response outputs hold stable until resp_valid&resp_ready; then drop resp_valid and go to IDLE.
  - chal_ready returns to 1 on the cycle after the handshake.
- ipulse pulse shape: high for exactly RACE_CYC consecutive cycles per evaluation, giving N_EVAL pulses per challenge.
- challenge bus: changes only on chal accept; stable through every race and through DONE.
- Latency: resp_valid asserts N_EVAL*(SETTLE_CYC+RACE_CYC+1) cycles after the accepting edge. Defaults: 195.
- No pipelining: one challenge in flight. chal_valid is ignored while busy, and chal_in is not sampled.
- Backpressure: resp_ready low in DONE holds state indefinitely, with no timeout.
- Counter width: ones saturation is impossible by construction (max N_EVAL fits CNT_W). No wrap.
- Reset mid-operation: abandons the evaluation, with no partial response and resp_valid=0. challenge returns to 0.

Decomposition:
- Package puf_pkg holds:
  - state enum {IDLE, SETTLE, RACE, SAMPLE, DONE};
  - default C_LENGTH;
  - clog2 helper for CNT_W.
- Sub-module sync_2ff: a 2-flop synchroniser for arb_resp with async active-high reset to 0.
- FSM, timer and counters stay in puf_eval_ctrl.

Test Plan:
- arb_resp tied 1, chal_in=32'hA5A55A5A -> resp_valid at cycle 195 after accept, resp=1, ones_count=15, unstable=0, challenge==32'hA5A55A5A throughout.
- arb_resp tied 0 -> resp=0, ones_count=0, unstable=0.
- arb_resp driven per evaluation (stable across each RACE) with 8 ones / 7 zeros -> resp=1, ones_count=8, unstable=1. With 7 ones -> resp=0, ones_count=7, unstable=1.
- Count ipulse activity over one challenge -> exactly 15 pulses, each high 8 cycles, separated by exactly 5 low cycles (SAMPLE+SETTLE).
- Hold resp_ready=0 for 20 cycles in DONE while toggling chal_valid -> outputs stable, chal_ready=0, no new accept. Raise resp_ready -> resp_valid drops next cycle, chal_ready=1.
- Assert rst during the 3rd RACE -> ipulse=0 asynchronously, resp_valid=0, challenge=0, busy=0. After release a new challenge completes normally in 195 cycles.
